// File: rtl/addsub_pkg.sv
// ============================================================================
// Module : addsub_pkg
// Brief  : Shared width default and operation encoding for the add/sub leaf.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

    localparam int ADDSUB_W_DEFAULT = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

endpackage : addsub_pkg

`default_nettype wire

// File: rtl/full_adder_1bit.sv
// ============================================================================
// Module : full_adder_1bit
// Brief  : One-bit full adder cell used to build the ripple-carry chain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

`default_nettype wire

// File: rtl/addsub_4bit.sv
// ============================================================================
// Module : addsub_4bit
// Brief  : Registered two's-complement ripple adder/subtractor with signed
//          overflow flag. Define ADDSUB_CARRY_OUT_EN to add the cout port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module addsub_4bit
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub
`ifdef ADDSUB_CARRY_OUT_EN
    ,
    output logic             cout
`endif
);

    addsub_op_e       w_op;
    logic [WIDTH-1:0] w_bb;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;
    logic             w_ovfl;

    logic [WIDTH-1:0] r_sum;
    logic             r_ovfl;

    assign w_op   = addsub_op_e'(sub);
    // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_c[0] = (w_op == OP_SUB);
    assign w_bb   = b ^ {WIDTH{w_c[0]}};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder_1bit u_fa (
                .a    (a[i]),
                .b    (w_bb[i]),
                .cin  (w_c[i]),
                .s    (w_s[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    assign w_ovfl = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_ovfl <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_ovfl <= w_ovfl;
        end
    end

    assign sum  = r_sum;
    assign ovfl = r_ovfl;

`ifdef ADDSUB_CARRY_OUT_EN
    logic r_cout;

    // For subtraction this is the inverted borrow: 1 means a >= b unsigned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cout <= 1'b0;
        end else begin
            r_cout <= w_c[WIDTH];
        end
    end

    assign cout = r_cout;
`endif

endmodule : addsub_4bit

`default_nettype wire

// File: tb/tb_addsub_4bit.sv
// ============================================================================
// Module : tb_addsub_4bit
// Brief  : Self-checking bench for addsub_4bit against an integer model.
//          Define ADDSUB_CARRY_OUT_EN to also check cout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_addsub_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sum;
    logic       ovfl;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
`ifdef ADDSUB_CARRY_OUT_EN
    logic       cout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sum   (sum),
        .ovfl  (ovfl),
        .a     (a),
        .b     (b),
        .sub   (sub)
`ifdef ADDSUB_CARRY_OUT_EN
        ,
        .cout  (cout)
`endif
    );

    // Reference: plain integer arithmetic on unsigned and signed readings.
    function automatic void model(input logic [3:0] ma, input logic [3:0] mb,
                                  input logic ms, output logic [3:0] es,
                                  output logic eo, output logic ec);
        int ua, ub, sa, sb, r;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        r  = ms ? sa - sb : sa + sb;
        es = ms ? 4'(ua - ub) : 4'(ua + ub);
        eo = (r > 7) || (r < -8);
        ec = ms ? (ua >= ub) : ((ua + ub) > 15);
    endfunction

    task automatic apply(input logic [3:0] ta, input logic [3:0] tb,
                         input logic ts, input logic trst, input string tag);
        logic [3:0] es;
        logic       eo;
        logic       ec;
        @(negedge clk);
        a     = ta;
        b     = tb;
        sub   = ts;
        rst_n = trst;
        if (trst) begin
            model(ta, tb, ts, es, eo, ec);
        end else begin
            es = 4'h0;
            eo = 1'b0;
            ec = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        assert (sum === es) else begin
            errors++;
            $error("FAIL %s sum: observed %h expected %h (a=%h b=%h sub=%b)",
                   tag, sum, es, ta, tb, ts);
        end
        checks++;
        assert (ovfl === eo) else begin
            errors++;
            $error("FAIL %s ovfl: observed %b expected %b (a=%h b=%h sub=%b)",
                   tag, ovfl, eo, ta, tb, ts);
        end
`ifdef ADDSUB_CARRY_OUT_EN
        checks++;
        assert (cout === ec) else begin
            errors++;
            $error("FAIL %s cout: observed %b expected %b (a=%h b=%h sub=%b)",
                   tag, cout, ec, ta, tb, ts);
        end
`endif
    endtask

    initial begin
        logic [7:0] v;
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        sub   = 1'b1;

        apply(4'hF, 4'hF, 1'b1, 1'b0, "reset0");
        apply(4'hF, 4'hF, 1'b1, 1'b0, "reset1");

        for (int i = 0; i < 100; i++) begin
            v = 8'($urandom_range(0, 255));
            apply(v[3:0], v[7:4], 1'b1, 1'b1, "sub_sweep");
        end

        apply(4'h7, 4'h1, 1'b0, 1'b1, "add_7p1");
        apply(4'h8, 4'hF, 1'b0, 1'b1, "add_m8m1");
        apply(4'h0, 4'h8, 1'b1, 1'b1, "sub_0m8");
        apply(4'h5, 4'h5, 1'b1, 1'b1, "sub_self");
        apply(4'h3, 4'h5, 1'b1, 1'b1, "borrow");
        apply(4'h8, 4'h1, 1'b1, 1'b1, "sub_m8m1");

        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom_range(0, 255));
            apply(v[3:0], v[7:4], 1'($urandom_range(0, 1)), 1'b1, "mixed");
        end

        apply(4'h6, 4'h3, 1'b0, 1'b1, "pre_rst0");
        apply(4'h2, 4'h9, 1'b1, 1'b1, "pre_rst1");
        apply(4'h7, 4'h7, 1'b0, 1'b0, "mid_rst");
        apply(4'h4, 4'hC, 1'b0, 1'b1, "post_rst0");
        apply(4'hA, 4'h3, 1'b1, 1'b1, "post_rst1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_addsub_4bit

`default_nettype wire
